// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and helpers for the register-file scoreboard.
// Holds the GPR geometry, Tnew/Tuse widths and the default write-back latency.
package rf_scoreboard_pkg;

    localparam int WB_LAT_DEF = 3;
    localparam int NGPR       = 32;
    localparam int REG_W      = 5;
    localparam int TNEW_W     = 2;
    localparam int TUSE_W     = 2;

    // Width of the per-register lifetime counter: must hold WB_LAT.
    function automatic int life_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rf_sb_entry.sv
// One scoreboard entry: Tnew and lifetime counters for a single GPR.
// Ports: clk, reset, load_i/tnew_i (new producer), tnew_o, busy_o.
module rf_sb_entry
    import rf_scoreboard_pkg::*;
#(
    parameter int WB_LAT = WB_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [TNEW_W-1:0] tnew_i,
    output logic [TNEW_W-1:0] tnew_o,
    output logic              busy_o
);

    localparam int                LIFE_W    = life_width(WB_LAT);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(WB_LAT);

    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [LIFE_W-1:0] life_q, life_d;

    // A new producer overwrites any older in-flight write (WAW).
    always_comb begin
        tnew_d = tnew_q;
        life_d = life_q;
        if (load_i) begin
            tnew_d = tnew_i;
            life_d = LIFE_INIT;
        end else begin
            if (tnew_q != '0) tnew_d = tnew_q - 1'b1;
            if (life_q != '0) life_d = life_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tnew_q <= '0;
            life_q <= '0;
        end else begin
            tnew_q <= tnew_d;
            life_q <= life_d;
        end
    end

    assign tnew_o = tnew_q;
    assign busy_o = (life_q != '0);

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: hazard stall, forwarding select, busy mask.
// Ports: issue_* (decode request), stall, rs_fwd/rt_fwd, busy_mask, stall_count.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int WB_LAT = WB_LAT_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_rs,
    input  logic [REG_W-1:0]  issue_rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [TUSE_W-1:0] tuse_rs,
    input  logic [TUSE_W-1:0] tuse_rt,
    input  logic              issue_wr_en,
    input  logic [REG_W-1:0]  issue_wr_reg,
    input  logic [TNEW_W-1:0] issue_tnew,
    output logic              stall,
    output logic              rs_fwd,
    output logic              rt_fwd,
    output logic [NGPR-1:0]   busy_mask,
    output logic [CNT_W-1:0]  stall_count
);

    logic [TNEW_W-1:0] tnew_a [NGPR];
    logic              busy_a [NGPR];
    logic              accept;
    logic              rs_hit, rt_hit;
    logic              rs_late, rt_late;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign accept = issue_valid && !stall;

    // GPR 0 is hard-wired and never tracked.
    assign tnew_a[0] = '0;
    assign busy_a[0] = 1'b0;

    for (genvar g = 1; g < NGPR; g++) begin : g_ent
        rf_sb_entry #(
            .WB_LAT (WB_LAT)
        ) u_ent (
            .clk    (clk),
            .reset  (reset),
            .load_i (accept && issue_wr_en &&
                     (issue_wr_reg == REG_W'(g))),
            .tnew_i (issue_tnew),
            .tnew_o (tnew_a[g]),
            .busy_o (busy_a[g])
        );
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NGPR; i++) busy_mask[i] = busy_a[i];
    end

    // Checks read the current entries, so a self-dependent issue
    // sees the older producer, not its own load.
    assign rs_hit  = use_rs && (issue_rs != '0) && busy_a[issue_rs];
    assign rt_hit  = use_rt && (issue_rt != '0) && busy_a[issue_rt];
    assign rs_late = rs_hit && (tnew_a[issue_rs] > tuse_rs);
    assign rt_late = rt_hit && (tnew_a[issue_rt] > tuse_rt);

    assign stall  = issue_valid && (rs_late || rt_late);
    assign rs_fwd = rs_hit;
    assign rt_fwd = rt_hit;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed hazard cases plus
// random traffic against a producer-timestamp reference model.
module tb_rf_scoreboard;

    localparam int WB_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs, issue_rt;
    logic        use_rs, use_rt;
    logic [1:0]  tuse_rs, tuse_rt;
    logic        issue_wr_en;
    logic [4:0]  issue_wr_reg;
    logic [1:0]  issue_tnew;
    logic        stall, rs_fwd, rt_fwd;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;
    logic        stall4, rs_fwd4, rt_fwd4;
    logic [31:0] busy_mask4;
    logic [3:0]  stall_count4;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each register remembers when its latest
    // producer was accepted and with which Tnew.
    int cyc;
    int wr_cyc [32];
    int wr_tnew [32];
    bit live [32];
    int m_cnt16, m_cnt4;

    always #5 clk = ~clk;

    rf_scoreboard #(.WB_LAT(WB_LAT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .use_rs(use_rs), .use_rt(use_rt),
        .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg),
        .issue_tnew(issue_tnew), .stall(stall),
        .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    rf_scoreboard #(.WB_LAT(WB_LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .use_rs(use_rs), .use_rt(use_rt),
        .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg),
        .issue_tnew(issue_tnew), .stall(stall4),
        .rs_fwd(rs_fwd4), .rt_fwd(rt_fwd4),
        .busy_mask(busy_mask4), .stall_count(stall_count4)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_busy(input int n);
        return (n != 0) && live[n] && ((cyc - wr_cyc[n]) <= WB_LAT);
    endfunction

    function automatic int m_rem(input int n);
        int r;
        r = wr_tnew[n] - (cyc - wr_cyc[n] - 1);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit m_late(input int n, input int tuse);
        return m_busy(n) && (m_rem(n) > tuse);
    endfunction

    task automatic idle();
        reset = 1'b0; issue_valid = 1'b0;
        issue_rs = '0; issue_rt = '0; use_rs = 1'b0; use_rt = 1'b0;
        tuse_rs = '0; tuse_rt = '0; issue_wr_en = 1'b0;
        issue_wr_reg = '0; issue_tnew = '0;
    endtask

    task automatic set_wr(input int r, input int tn);
        idle();
        issue_valid = 1'b1; issue_wr_en = 1'b1;
        issue_wr_reg = 5'(r); issue_tnew = 2'(tn);
    endtask

    task automatic set_rd(input int rs, input int tus,
                          input int rt, input int tut);
        idle();
        issue_valid = 1'b1;
        issue_rs = 5'(rs); use_rs = (rs >= 0);
        issue_rt = 5'(rt); use_rt = (rt >= 0);
        tuse_rs = 2'(tus); tuse_rt = 2'(tut);
        if (rs < 0) issue_rs = '0;
        if (rt < 0) issue_rt = '0;
    endtask

    // Check the current cycle against the model, then cross one edge.
    task automatic step();
        bit e_rsf, e_rtf, e_stall;
        logic [31:0] e_mask;
        #1;
        e_rsf = use_rs && m_busy(int'(issue_rs));
        e_rtf = use_rt && m_busy(int'(issue_rt));
        e_stall = issue_valid &&
                  ((use_rs && m_late(int'(issue_rs), int'(tuse_rs))) ||
                   (use_rt && m_late(int'(issue_rt), int'(tuse_rt))));
        e_mask = '0;
        for (int i = 0; i < 32; i++) e_mask[i] = m_busy(i);
        check("stall", 64'(stall), 64'(e_stall));
        check("rs_fwd", 64'(rs_fwd), 64'(e_rsf));
        check("rt_fwd", 64'(rt_fwd), 64'(e_rtf));
        check("busy_mask", 64'(busy_mask), 64'(e_mask));
        check("stall_count", 64'(stall_count), 64'(m_cnt16));
        check("stall_count4", 64'(stall_count4), 64'(m_cnt4));
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) live[i] = 1'b0;
            m_cnt16 = 0; m_cnt4 = 0;
        end else begin
            if (e_stall) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (issue_valid && !e_stall && issue_wr_en &&
                issue_wr_reg != 0) begin
                wr_cyc[issue_wr_reg]  = cyc;
                wr_tnew[issue_wr_reg] = int'(issue_tnew);
                live[issue_wr_reg]    = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; step(); idle();
    endtask

    initial begin
        cyc = 0; m_cnt16 = 0; m_cnt4 = 0;
        for (int i = 0; i < 32; i++) begin
            live[i] = 1'b0; wr_cyc[i] = 0; wr_tnew[i] = 0;
        end
        idle();
        reset = 1'b1;
        @(negedge clk);
        step();
        idle();
        #1;
        check("rst_busy", 64'(busy_mask), 64'(0));
        check("rst_cnt", 64'(stall_count), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));

        // load-use
        set_wr(8, 2); step();
        set_rd(8, 0, -1, 0); #1;
        check("lw_stall_c1", 64'(stall), 64'(1)); step();
        #1; check("lw_stall_c2", 64'(stall), 64'(1)); step();
        #1; check("lw_stall_c3", 64'(stall), 64'(0));
        check("lw_fwd_c3", 64'(rs_fwd), 64'(1)); step();
        idle(); #1;
        check("lw_cnt", 64'(stall_count), 64'(2));
        step(); step(); step();

        // ALU chain
        do_reset();
        set_wr(9, 1); step();
        set_rd(-1, 0, 9, 1); #1;
        check("alu_stall", 64'(stall), 64'(0));
        check("alu_fwd", 64'(rt_fwd), 64'(1)); step();
        idle(); step(); step();
        set_rd(-1, 0, 9, 1); #1;
        check("alu_fwd_c4", 64'(rt_fwd), 64'(0));
        check("alu_busy_c4", 64'(busy_mask[9]), 64'(0)); step();

        // zero register
        set_wr(0, 2); step();
        set_rd(0, 0, 0, 0); #1;
        check("r0_stall", 64'(stall), 64'(0));
        check("r0_fwd", 64'(rs_fwd), 64'(0));
        check("r0_busy", 64'(busy_mask), 64'(0)); step();

        // WAW
        do_reset();
        set_wr(5, 2); step();
        set_wr(5, 0); step();
        set_rd(5, 0, -1, 0); #1;
        check("waw_stall", 64'(stall), 64'(0)); step();
        idle(); step();
        #1; check("waw_busy_c4", 64'(busy_mask[5]), 64'(1)); step();
        #1; check("waw_busy_c5", 64'(busy_mask[5]), 64'(0));

        // reset mid-operation
        set_wr(3, 2); step();
        set_rd(3, 0, -1, 0); reset = 1'b1; step();
        set_rd(3, 0, -1, 0); #1;
        check("rmid_busy", 64'(busy_mask), 64'(0));
        check("rmid_stall", 64'(stall), 64'(0));
        check("rmid_cnt", 64'(stall_count), 64'(0)); step();

        // self-dependence and rs==rt
        set_wr(7, 2); step();
        set_rd(7, 0, 7, 0);
        issue_wr_en = 1'b1; issue_wr_reg = 5'd7; issue_tnew = 2'd1;
        step(); step(); step();
        idle(); step(); step();

        // saturation: 10 producers, each giving two stalls
        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_wr(12, 2); step();
            set_rd(12, 0, -1, 0); step(); step(); step();
        end
        idle(); #1;
        check("sat_cnt4", 64'(stall_count4), 64'(15));
        check("sat_cnt16", 64'(stall_count), 64'(20));
        step();
        #1; check("sat_hold", 64'(stall_count4), 64'(15));

        // random traffic
        do_reset();
        for (int k = 0; k < 600; k++) begin
            idle();
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_rs     = 5'($urandom_range(0, 7));
            issue_rt     = 5'($urandom_range(0, 7));
            use_rs       = 1'($urandom);
            use_rt       = 1'($urandom);
            tuse_rs      = 2'($urandom);
            tuse_rt      = 2'($urandom);
            issue_wr_en  = 1'($urandom);
            issue_wr_reg = 5'($urandom_range(0, 7));
            issue_tnew   = 2'($urandom_range(0, WB_LAT - 1));
            reset        = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
